// File: rtl/tft_fb_arbiter_if.sv
// Bundle of the display, writer and frame-RAM signals around tft_fb_arbiter.
// The arbiter takes the slave view; whoever drives the clients and models the RAM takes master.
interface tft_fb_arbiter_if #(
   parameter int ADDR_W = 17
);
   logic              pix_req;
   logic [15:0]       pix_data;
   logic              frame_sync;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              wr_ack;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_re;
   logic              ram_we;
   logic [15:0]       ram_wdata;
   logic [15:0]       ram_rdata;
   logic              underrun;

   modport slave (
      input  pix_req, frame_sync, wr_req, wr_addr, wr_data, ram_rdata,
      output pix_data, wr_ack, ram_addr, ram_re, ram_we, ram_wdata, underrun
   );

   modport master (
      output pix_req, frame_sync, wr_req, wr_addr, wr_data, ram_rdata,
      input  pix_data, wr_ack, ram_addr, ram_re, ram_we, ram_wdata, underrun
   );
endinterface

// File: rtl/tft_fb_arbiter.sv
// Frame-RAM arbiter: keeps a small prefetch FIFO topped up for TFT scan-out and
// gives every RAM slot the display does not need to the drawing client.
module tft_fb_arbiter #(
   parameter int PIXELS         = 76800,
   parameter int ADDR_W         = 17,
   parameter int PREFETCH_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   tft_fb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(PREFETCH_DEPTH);
   localparam int CNT_W = $clog2(PREFETCH_DEPTH + 1);
   localparam int CR_W  = CNT_W + 1;

   logic [15:0]       fifo_q [PREFETCH_DEPTH];
   logic [15:0]       fifo_d [PREFETCH_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] scan_q, scan_d;
   logic              pix_req_q;
   logic              fill_pend_q, fill_pend_d;
   logic [15:0]       pix_data_q, pix_data_d;
   logic              wr_ack_q, wr_ack_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_re_q, ram_re_d;
   logic              ram_we_q, ram_we_d;
   logic [15:0]       ram_wdata_q, ram_wdata_d;
   logic              underrun_q, underrun_d;

   logic              sync_s, pop_s, pop_ok_s, fill_s;
   logic [CR_W-1:0]   credit_s;
   logic              disp_rd_s, wr_grant_s, wr_ok_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(PREFETCH_DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Reads in flight are the one on ram_re now plus the one whose data returns now.
   always_comb begin
      sync_s     = bus.frame_sync;
      pop_s      = bus.pix_req & ~pix_req_q & ~sync_s;
      pop_ok_s   = pop_s & (count_q != {CNT_W{1'b0}});
      fill_s     = fill_pend_q & ~sync_s;
      credit_s   = CR_W'(count_q) + CR_W'(ram_re_q) + CR_W'(fill_pend_q) - CR_W'(pop_ok_s);
      disp_rd_s  = ~sync_s & (credit_s < CR_W'(PREFETCH_DEPTH));
      wr_grant_s = ~disp_rd_s & bus.wr_req & ~wr_ack_q;
      wr_ok_s    = wr_grant_s & (32'(bus.wr_addr) < 32'(PIXELS));
   end

   // FIFO contents, pointers, head pixel and scan address
   always_comb begin
      fifo_d   = fifo_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (sync_s) begin
         rd_ptr_d = {PTR_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (fill_s) begin
            fifo_d[wr_ptr_q] = bus.ram_rdata;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CNT_W'(fill_s) - CNT_W'(pop_ok_s);
      end
      pix_data_d = (count_d != {CNT_W{1'b0}}) ? fifo_d[rd_ptr_d] : pix_data_q;
      if (sync_s) begin
         scan_d = {ADDR_W{1'b0}};
      end else if (disp_rd_s) begin
         scan_d = (scan_q == ADDR_W'(PIXELS - 1)) ? {ADDR_W{1'b0}} : scan_q + ADDR_W'(1);
      end else begin
         scan_d = scan_q;
      end
   end

   // RAM command, writer acknowledge and sticky underrun
   always_comb begin
      ram_re_d    = disp_rd_s;
      ram_we_d    = wr_ok_s;
      wr_ack_d    = wr_grant_s;
      fill_pend_d = ram_re_q & ~sync_s;
      underrun_d  = underrun_q | (pop_s & (count_q == {CNT_W{1'b0}}));
      if (disp_rd_s) begin
         ram_addr_d  = scan_q;
         ram_wdata_d = ram_wdata_q;
      end else if (wr_ok_s) begin
         ram_addr_d  = bus.wr_addr;
         ram_wdata_d = bus.wr_data;
      end else begin
         ram_addr_d  = ram_addr_q;
         ram_wdata_d = ram_wdata_q;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            fifo_q[i] <= 16'h0000;
         end
         rd_ptr_q    <= {PTR_W{1'b0}};
         wr_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         scan_q      <= {ADDR_W{1'b0}};
         pix_req_q   <= 1'b0;
         fill_pend_q <= 1'b0;
         pix_data_q  <= 16'h0000;
         wr_ack_q    <= 1'b0;
         ram_addr_q  <= {ADDR_W{1'b0}};
         ram_re_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= 16'h0000;
         underrun_q  <= 1'b0;
      end else begin
         fifo_q      <= fifo_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         scan_q      <= scan_d;
         pix_req_q   <= bus.pix_req;
         fill_pend_q <= fill_pend_d;
         pix_data_q  <= pix_data_d;
         wr_ack_q    <= wr_ack_d;
         ram_addr_q  <= ram_addr_d;
         ram_re_q    <= ram_re_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.pix_data  = pix_data_q;
   assign bus.wr_ack    = wr_ack_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_re    = ram_re_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_tft_fb_arbiter.sv
// Bench for tft_fb_arbiter: fixed reset-fill vectors, hand-written writer/sync sequences,
// a full scan wrap and random traffic against a queue-based reference model.
module tb_tft_fb_arbiter;
   localparam int P  = 1000;
   localparam int D  = 2;
   localparam int AW = 17;

   logic clk;
   logic reset;
   tft_fb_arbiter_if #(.ADDR_W(AW)) bus ();

   tft_fb_arbiter #(.PIXELS(P), .ADDR_W(AW), .PREFETCH_DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Frame RAM: contents initialised on the first edge, one-cycle read latency
   logic [15:0] mem [P];
   bit          mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < P; i++) mem[i] <= 16'hC000 | 16'(i);
         mem_ready <= 1'b1;
      end else begin
         if (bus.ram_re && 32'(bus.ram_addr) < P) bus.ram_rdata <= mem[bus.ram_addr];
         if (bus.ram_we && 32'(bus.ram_addr) < P) mem[bus.ram_addr] <= bus.ram_wdata;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pixel queue, queue of reads in flight, shadow RAM
   typedef struct { logic [15:0] val; int ttl; } pend_t;
   logic [15:0] mref [P];
   logic [15:0] m_fifo [$];
   pend_t       pend [$];
   int          m_scan;
   bit          m_prev_req, m_under, chk_en;
   logic        e_re, e_we, e_ack, e_under;
   logic [AW-1:0] e_addr;
   logic [15:0] e_wdata, e_pd;

   task automatic model_check();
      if (chk_en) begin
         chk("m_ram_re", bus.ram_re, e_re);
         chk("m_ram_we", bus.ram_we, e_we);
         chk("m_ram_addr", bus.ram_addr, e_addr);
         chk("m_ram_wdata", bus.ram_wdata, e_wdata);
         chk("m_wr_ack", bus.wr_ack, e_ack);
         chk("m_pix_data", bus.pix_data, e_pd);
         chk("m_underrun", bus.underrun, e_under);
      end
   endtask

   task automatic model_step();
      bit    pop, disp, ack;
      int    credit;
      pend_t t;
      if (reset) begin
         m_scan = 0; m_fifo.delete(); pend.delete(); m_prev_req = 0; m_under = 0;
         e_re = 0; e_we = 0; e_ack = 0; e_under = 0; e_addr = '0; e_wdata = '0; e_pd = '0;
         chk_en = 1;
         return;
      end
      pop = bus.pix_req && !m_prev_req;
      m_prev_req = bus.pix_req;
      if (bus.frame_sync) begin
         m_fifo.delete(); pend.delete(); m_scan = 0;
      end else if (pop) begin
         if (m_fifo.size() > 0) void'(m_fifo.pop_front());
         else m_under = 1;
      end
      credit = m_fifo.size() + pend.size();
      disp = !bus.frame_sync && credit < D;
      for (int i = 0; i < pend.size(); i++) pend[i].ttl--;
      while (pend.size() > 0 && pend[0].ttl == 0) begin
         t = pend.pop_front();
         m_fifo.push_back(t.val);
      end
      e_re = 0; e_we = 0; ack = 0;
      if (disp) begin
         t.val = mref[m_scan]; t.ttl = 2;
         pend.push_back(t);
         e_re = 1; e_addr = AW'(m_scan);
         m_scan = (m_scan == P - 1) ? 0 : m_scan + 1;
      end else if (bus.wr_req && !e_ack) begin
         ack = 1;
         if (32'(bus.wr_addr) < P) begin
            mref[bus.wr_addr] = bus.wr_data;
            e_we = 1; e_addr = bus.wr_addr; e_wdata = bus.wr_data;
         end
      end
      e_ack = ack;
      if (m_fifo.size() > 0) e_pd = m_fifo[0];
      e_under = m_under;
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct { logic pix_req; logic e_re; logic [AW-1:0] e_addr; logic [15:0] e_pd; } vec_t;
   vec_t tbl [14];

   initial begin
      int          cnt, waited;
      bit          ack_hold;
      logic [AW-1:0] bad_addr [2];

      tbl[0]  = '{1'b0, 1'b0, 17'd0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, 17'd0, 16'h0000};
      tbl[2]  = '{1'b0, 1'b1, 17'd1, 16'h0000};
      for (int i = 3; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 17'd1, 16'hC000};
      tbl[10] = '{1'b1, 1'b0, 17'd1, 16'hC000};
      tbl[11] = '{1'b1, 1'b1, 17'd2, 16'hC001};
      tbl[12] = '{1'b0, 1'b0, 17'd2, 16'hC001};
      tbl[13] = '{1'b0, 1'b0, 17'd2, 16'hC001};
      bad_addr[0] = 17'(P);
      bad_addr[1] = 17'd76800;

      for (int i = 0; i < P; i++) mref[i] = 16'hC000 | 16'(i);
      chk_en = 0; e_ack = 0;
      reset = 1'b1;
      bus.pix_req = 1'b0; bus.frame_sync = 1'b0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = 16'h0000;
      @(posedge clk); #1;
      cycle(); cycle();
      reset = 1'b0;

      // Reset fill with the display idle, then one pop
      for (int i = 0; i < 14; i++) begin
         bus.pix_req = tbl[i].pix_req;
         chk("tbl_ram_re", bus.ram_re, tbl[i].e_re);
         chk("tbl_ram_addr", bus.ram_addr, tbl[i].e_addr);
         chk("tbl_pix_data", bus.pix_data, tbl[i].e_pd);
         chk("tbl_underrun", bus.underrun, 1'b0);
         cycle();
      end

      // Held write with the display satisfied: one write, ack after one cycle
      bus.wr_req = 1'b1; bus.wr_addr = 17'd100; bus.wr_data = 16'hF800;
      cycle();
      chk("wr1_we", bus.ram_we, 1'b1);
      chk("wr1_ack", bus.wr_ack, 1'b1);
      chk("wr1_addr", bus.ram_addr, 17'd100);
      chk("wr1_wdata", bus.ram_wdata, 16'hF800);
      cycle();
      bus.wr_req = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cnt += int'(bus.ram_we);
         cycle();
      end
      chk("wr1_no_second_write", cnt, 0);
      chk("wr1_ram100", mem[100], 16'hF800);

      // Pop and write request together: display read first, writer soon after
      bus.pix_req = 1'b1;
      bus.wr_req = 1'b1; bus.wr_addr = 17'd101; bus.wr_data = 16'h07E0;
      cycle();
      chk("pw_disp_first", {bus.ram_re, bus.ram_we, bus.wr_ack}, 3'b100);
      waited = 0;
      for (int i = 1; i <= 3 && waited == 0; i++) begin
         cycle();
         if (bus.wr_ack) waited = i + 1;
      end
      chk("pw_writer_granted", (waited != 0 && waited <= 3), 1'b1);
      cycle();
      bus.wr_req = 1'b0; bus.pix_req = 1'b0;
      cycle();
      chk("pw_ram101", mem[101], 16'h07E0);

      // Out-of-range writes are acknowledged but never reach the RAM
      for (int k = 0; k < 2; k++) begin
         bus.wr_req = 1'b1; bus.wr_addr = bad_addr[k]; bus.wr_data = 16'h1234;
         cycle();
         chk("bad_ack", bus.wr_ack, 1'b1);
         chk("bad_no_we", bus.ram_we, 1'b0);
         cycle();
         bus.wr_req = 1'b0;
         cycle();
      end

      // frame_sync with a read in flight and a coincident pop
      bus.pix_req = 1'b1; cycle();
      bus.pix_req = 1'b0; cycle();
      bus.pix_req = 1'b1; bus.frame_sync = 1'b1; cycle();
      bus.pix_req = 1'b0; bus.frame_sync = 1'b0;
      chk("sync_no_read", bus.ram_re, 1'b0);
      cycle();
      chk("sync_read_re", bus.ram_re, 1'b1);
      chk("sync_read_addr0", bus.ram_addr, 17'd0);
      chk("sync_no_underrun", bus.underrun, 1'b0);
      bus.pix_req = 1'b1; cycle();
      bus.pix_req = 1'b0;
      chk("empty_pop_underrun", bus.underrun, 1'b1);
      cycle();
      chk("sync_refill_addr0", bus.pix_data, 16'hC000);
      for (int i = 0; i < 5; i++) cycle();
      chk("underrun_sticky", bus.underrun, 1'b1);
      reset = 1'b1; cycle(); reset = 1'b0;
      chk("underrun_reset", bus.underrun, 1'b0);

      // Whole-frame scan with wrap: every pixel in order, no underrun
      for (int i = 0; i < 10; i++) cycle();
      for (int k = 0; k < P + 2; k++) begin
         chk("scan_pixel", bus.pix_data, mref[k % P]);
         bus.pix_req = 1'b1; cycle(); cycle();
         bus.pix_req = 1'b0; cycle(); cycle();
      end
      chk("scan_no_underrun", bus.underrun, 1'b0);

      // Random traffic against the reference model
      ack_hold = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 2) == 0) bus.pix_req = ~bus.pix_req;
         bus.frame_sync = ($urandom_range(0, 149) == 0);
         reset = ($urandom_range(0, 999) == 0);
         if (bus.wr_req && ack_hold) begin
            bus.wr_req = 1'b0; ack_hold = 0;
         end else if (bus.wr_req && bus.wr_ack) begin
            ack_hold = 1;
         end else if (!bus.wr_req && $urandom_range(0, 3) == 0) begin
            bus.wr_req = 1'b1;
            bus.wr_data = 16'($urandom);
            if ($urandom_range(0, 9) == 0) bus.wr_addr = 17'(P + $urandom_range(0, 80000));
            else bus.wr_addr = 17'($urandom_range(0, P - 1));
         end
         cycle();
      end
      reset = 1'b0; bus.frame_sync = 1'b0;
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
